// File: rtl/batchnorm_stream_layer_if.sv
// Vector stream bundle for the batch-normalisation stage: input handshake,
// static per-element coefficients and registered output handshake.
interface batchnorm_stream_layer_if #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 64
);
    logic                         in_valid;
    logic                         in_ready;
    logic [SIZE-1:0][WIDTH-1:0]   input_data;
    logic [SIZE-1:0][WIDTH-1:0]   scale;
    logic [SIZE-1:0][WIDTH-1:0]   bias;
    logic                         out_valid;
    logic                         out_ready;
    logic [SIZE-1:0][WIDTH-1:0]   output_data;

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid,
        output input_data,
        output scale,
        output bias,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  output_data
    );

    // Batch-norm stage side
    modport slave (
        input  in_valid,
        input  input_data,
        input  scale,
        input  bias,
        input  out_ready,
        output in_ready,
        output out_valid,
        output output_data
    );
endinterface

// File: rtl/batchnorm_stream_layer.sv
// Time-multiplexed batch-norm stage: y[i] = sat(floor(x[i]*scale[i] >> NFRAC) + bias[i]),
// LANES elements per beat. Define BN_FUSED_RELU_EN to clamp negative results to zero.
module batchnorm_stream_layer #(
    parameter int WIDTH = 16,
    parameter int NFRAC = 10,
    parameter int SIZE  = 64,
    parameter int LANES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    batchnorm_stream_layer_if.slave  bus
);
    localparam int N       = SIZE / LANES;
    localparam int BEAT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W   = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int PROD_W  = 2 * WIDTH;
    // The sum must hold both the shifted product and the extended bias without wrapping.
    localparam int SUM_A   = WIDTH + NFRAC + 1;
    localparam int SUM_B   = 2 * WIDTH - NFRAC + 1;
    localparam int SUM_W   = (SUM_A > SUM_B) ? SUM_A : SUM_B;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        $signed({{(SUM_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        $signed({{(SUM_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    if (SIZE % LANES != 0) begin : g_size_check
        $error("batchnorm_stream_layer: SIZE must be a multiple of LANES");
    end

    logic [1:0]                  r_state;
    logic [BEAT_W-1:0]           r_beat;
    logic [SIZE-1:0][WIDTH-1:0]  r_x_buf;
    logic [SIZE-1:0][WIDTH-1:0]  r_out;

    logic [IDX_W-1:0]            w_lane_idx [LANES];
    logic [WIDTH-1:0]            w_y        [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [WIDTH-1:0]  w_x;
        logic signed [WIDTH-1:0]  w_scale;
        logic signed [WIDTH-1:0]  w_bias;
        logic signed [PROD_W-1:0] w_prod;
        logic signed [SUM_W-1:0]  w_q;
        logic signed [SUM_W-1:0]  w_sum;
        logic        [WIDTH-1:0]  w_sat;

        assign w_lane_idx[gi] = IDX_W'(int'(r_beat) * LANES + gi);

        assign w_x     = r_x_buf[w_lane_idx[gi]];
        assign w_scale = bus.scale[w_lane_idx[gi]];
        assign w_bias  = bus.bias[w_lane_idx[gi]];

        assign w_prod  = w_x * w_scale;
        // Arithmetic shift floors toward minus infinity, so -1/1024 stays -1.
        assign w_q     = SUM_W'(w_prod >>> NFRAC);
        assign w_sum   = w_q + SUM_W'(w_bias);

        always_comb begin
            w_sat = w_sum[WIDTH-1:0];
            if (w_sum > SAT_MAX) begin
                w_sat = SAT_MAX[WIDTH-1:0];
            end else if (w_sum < SAT_MIN) begin
                w_sat = SAT_MIN[WIDTH-1:0];
            end
        end

`ifdef BN_FUSED_RELU_EN
        assign w_y[gi] = w_sat[WIDTH-1] ? '0 : w_sat;
`else
        assign w_y[gi] = w_sat;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_beat  <= '0;
                        r_state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    for (int li = 0; li < LANES; li++) begin
                        r_out[w_lane_idx[li]] <= w_y[li];
                    end
                    if (r_beat == LAST_BEAT) begin
                        r_beat  <= '0;
                        r_state <= S_HOLD;
                    end else begin
                        r_beat  <= r_beat + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_beat  <= '0;
                end
            endcase
        end
    end

    // The operand buffer needs no reset: it is only read after a fresh capture.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_IDLE && bus.in_valid) begin
            r_x_buf <= bus.input_data;
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = (r_state == S_HOLD);
    assign bus.output_data = r_out;
endmodule

// File: tb/tb_batchnorm_stream_layer.sv
// Directed, table-driven bench for batchnorm_stream_layer (default parameters),
// with hand-written backpressure, no-overlap and mid-compute reset sequences.
module tb_batchnorm_stream_layer;
    localparam int W  = 16;
    localparam int SZ = 64;
    localparam int LN = 8;
    localparam int NB = SZ / LN;
    localparam int NV = 11;

    typedef logic [SZ-1:0][W-1:0] vec_t;
    typedef struct {
        int x;
        int s;
        int b;
        int y;
        int y_relu;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;
    rec_t tbl [NV];

    batchnorm_stream_layer_if #(.WIDTH(W), .SIZE(SZ)) bus ();

    batchnorm_stream_layer #(.WIDTH(W), .NFRAC(10), .SIZE(SZ), .LANES(LN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t fill(input int v);
        vec_t r;
        for (int i = 0; i < SZ; i++) r[i] = W'(v);
        return r;
    endfunction

    function automatic int pick(input int y, input int y_relu);
`ifdef BN_FUSED_RELU_EN
        return y_relu;
`else
        return y;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b need %0b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d need %0d", nm, act, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input vec_t act, input vec_t exp);
        int nbad;
        int first;
        nbad  = 0;
        first = -1;
        for (int i = 0; i < SZ; i++) begin
            if (act[i] !== exp[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        n_chk++;
        if (nbad != 0) begin
            n_err++;
            $display("FAIL %s: y[%0d] got %0d need %0d (%0d elements differ)",
                     nm, first, $signed(act[first]), $signed(exp[first]), nbad);
        end
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_vec(input string nm, input vec_t x, input vec_t s,
                           input vec_t b, input vec_t exp);
        int guard;
        int cyc;
        bus.scale      = s;
        bus.bias       = b;
        bus.input_data = x;
        bus.in_valid   = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 40) begin
            tick();
            guard++;
        end
        chk_bit({nm, " in_ready"}, bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        wait_out(cyc);
        chk_int({nm, " latency"}, cyc, NB);
        chk_vec({nm, " data"}, bus.output_data, exp);
        $display("txn %s: latency=%0d y[0]=%0d y[%0d]=%0d", nm, cyc,
                 $signed(bus.output_data[0]), SZ - 1, $signed(bus.output_data[SZ-1]));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk_bit({nm, " consumed"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        vec_t xv;
        vec_t bv;
        vec_t ev;
        vec_t snap;
        int   cyc;
        logic saw_valid;

        //        x       scale   bias    y       y with fused ReLU
        tbl[0]  = '{1024,   2048,   512,    2560,   2560};
        tbl[1]  = '{32767,  2048,   0,      32767,  32767};
        tbl[2]  = '{-32768, 2048,   0,      -32768, 0};
        tbl[3]  = '{-1,     1,      0,      -1,     0};
        tbl[4]  = '{1024,   -1024,  0,      -1024,  0};
        tbl[5]  = '{3000,   512,    -100,   1400,   1400};
        tbl[6]  = '{1,      1,      0,      0,      0};
        tbl[7]  = '{1024,   1024,   32767,  32767,  32767};
        tbl[8]  = '{-3,     1000,   0,      -3,     0};
        tbl[9]  = '{0,      5,      -32768, -32768, 0};
        tbl[10] = '{-32768, -32768, 0,      32767,  32767};

        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.input_data = '0;
        bus.scale      = '0;
        bus.bias       = '0;

        tick();
        tick();
        rst = 1'b0;
        chk_bit("reset in_ready", bus.in_ready, 1'b1);
        chk_bit("reset out_valid", bus.out_valid, 1'b0);
        chk_vec("reset data", bus.output_data, '0);

        // out_ready outside HOLD must not disturb the idle stage
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        chk_bit("idle out_ready in_ready", bus.in_ready, 1'b1);
        chk_bit("idle out_ready out_valid", bus.out_valid, 1'b0);

        for (int v = 0; v < NV; v++) begin
            run_vec($sformatf("vec%0d", v), fill(tbl[v].x), fill(tbl[v].s),
                    fill(tbl[v].b), fill(pick(tbl[v].y, tbl[v].y_relu)));
        end

        // Per-element indexing: every element gets a distinct operand
        for (int i = 0; i < SZ; i++) begin
            xv[i] = W'(i * 256);
            bv[i] = W'(-i * 256);
        end
        run_vec("lane_zero", xv, fill(1024), bv, '0);
        for (int i = 0; i < SZ; i++) begin
            bv[i] = W'(i);
            ev[i] = W'(i * 257);
        end
        run_vec("lane_ramp", xv, fill(1024), bv, ev);

        // Backpressure: result held for 10 cycles while in_valid pulses are ignored
        bus.scale      = fill(2048);
        bus.bias       = fill(512);
        bus.input_data = fill(1024);
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out(cyc);
        chk_int("bp latency", cyc, NB);
        snap = fill(2560);
        chk_vec("bp data", bus.output_data, snap);
        for (int k = 0; k < 10; k++) begin
            bus.input_data = fill(7 + k);
            bus.in_valid   = k[0];
            tick();
            chk_bit($sformatf("bp%0d out_valid", k), bus.out_valid, 1'b1);
            chk_bit($sformatf("bp%0d in_ready", k), bus.in_ready, 1'b0);
            chk_vec($sformatf("bp%0d data", k), bus.output_data, snap);
        end
        // Consume while a new vector is offered: no same-cycle accept
        bus.input_data = fill(2048);
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk_bit("overlap out_valid", bus.out_valid, 1'b0);
        chk_bit("overlap in_ready", bus.in_ready, 1'b1);
        chk_vec("overlap data kept", bus.output_data, snap);
        tick();
        bus.in_valid = 1'b0;
        chk_bit("overlap accepted", bus.in_ready, 1'b0);
        wait_out(cyc);
        chk_int("overlap latency", cyc, NB);
        chk_vec("overlap data", bus.output_data, fill(4608));
        $display("txn overlap: latency=%0d y[0]=%0d", cyc, $signed(bus.output_data[0]));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset at beat 3 discards the partial result
        bus.input_data = fill(1024);
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_bit("midrst out_valid", bus.out_valid, 1'b0);
        chk_bit("midrst in_ready", bus.in_ready, 1'b1);
        chk_vec("midrst data", bus.output_data, '0);
        saw_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.out_valid) saw_valid = 1'b1;
        end
        chk_bit("midrst no pulse", saw_valid, 1'b0);
        $display("txn midrst: reset at beat 3");
        run_vec("after_rst", fill(1024), fill(2048), fill(512), fill(2560));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
